async_fifo_wr_arbiter: RTL and testbench



---
 rtl/async_fifo_wr_arbiter_pkg.sv | 17 +
 rtl/async_fifo_wr_arbiter_rr_priority_picker.sv | 35 +++
 rtl/async_fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async FIFO port arbiters.
// No logic of its own; compile-time only.
// Imported by the arbiter top and the round-robin picker.
package async_fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit so that
  // a single-requester build still has a legal index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request after the pointer, wrapping modulo NUM_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only reports who would win, the caller decides when to take it.
module rr_priority_picker
  import async_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               gnt_vld_o
);

  // Search ptr+1, ptr+2, ... ptr+NUM_REQ; the pointer itself is checked last.
  always_comb begin
    logic found;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % NUM_REQ))) begin
          found       = 1'b1;
          gnt_oh_o[i] = 1'b1;
          gnt_idx_o   = IW'(i);
        end
      end
    end
    gnt_vld_o = found;
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Shares one async_fifo write port among NUM_REQ requesters, round-robin per packet.
// Latency: one-cycle arbitration bubble per grant; beats pass to wr_en/wr_data combinationally.
// Backpressure: fifo_full stalls only the owner (its ready drops); non-owners wait unready.
module async_fifo_wr_arbiter
  import async_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int MAX_BURST    = 4,
  parameter  int IDLE_TIMEOUT = 8,
  localparam int IW           = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_active,
  output logic [IW-1:0]                 grant_idx
);

  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int IDW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0]  BURST_END = BW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] IDLE_END  = IDW'(IDLE_TIMEOUT - 1);

  arb_state_e           state_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        grant_idx_q;
  logic [NUM_REQ-1:0]   grant_oh_q;
  logic                 grant_active_q;
  logic [BW-1:0]        beat_cnt_q;
  logic [IDW-1:0]       idle_cnt_q;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;

  logic                 owner_vld;
  logic                 owner_last;
  logic [DATA_WIDTH-1:0] owner_dat;
  logic                 accept;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  // Select the owner's valid/last/data through the registered one-hot grant.
  always_comb begin
    owner_vld  = |(req_valid & grant_oh_q);
    owner_last = |(req_last & grant_oh_q);
    owner_dat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_q[i]) begin
        owner_dat = owner_dat | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A beat moves only when the owner offers it and the FIFO has room; full is never overridden.
  assign accept       = grant_active_q & owner_vld & ~fifo_full;
  assign fifo_wr_en   = accept;
  assign fifo_wr_data = grant_active_q ? owner_dat : '0;
  assign req_ready    = (grant_active_q && !fifo_full) ? grant_oh_q : '0;
  assign grant_active = grant_active_q;
  assign grant_idx    = grant_idx_q;

  // Arbitration FSM: pick in IDLE, hold the grant until last beat, burst limit or idle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      rr_ptr_q       <= IW'(NUM_REQ - 1);
      grant_idx_q    <= '0;
      grant_oh_q     <= '0;
      grant_active_q <= 1'b0;
      beat_cnt_q     <= '0;
      idle_cnt_q     <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_vld) begin
            state_q        <= ARB_GRANT;
            grant_idx_q    <= pick_idx;
            grant_oh_q     <= pick_oh;
            grant_active_q <= 1'b1;
            beat_cnt_q     <= '0;
            idle_cnt_q     <= '0;
          end
        end
        ARB_GRANT: begin
          if (accept) begin
            idle_cnt_q <= '0;
            if (owner_last || (beat_cnt_q == BURST_END)) begin
              // Packet done or burst budget spent: hand the port back.
              state_q        <= ARB_IDLE;
              grant_active_q <= 1'b0;
              rr_ptr_q       <= grant_idx_q;
              beat_cnt_q     <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end else if (!owner_vld) begin
            // Owner has gone quiet; a stalled-by-full owner does not count here.
            if (idle_cnt_q == IDLE_END) begin
              state_q        <= ARB_IDLE;
              grant_active_q <= 1'b0;
              rr_ptr_q       <= grant_idx_q;
              beat_cnt_q     <= '0;
              idle_cnt_q     <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + IDW'(1);
            end
          end
        end
        default: begin
          state_q        <= ARB_IDLE;
          grant_active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter with four packet sources.
// Each window starts 1 ns after a rising edge; inputs change there, outputs are read before the next edge.
// Handshakes and FIFO writes are sampled on the falling edge.
module tb_async_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              grant_active;
  logic [1:0]        grant_idx;

  int vec;
  int errs;

  int            src_left [N];
  int            src_plen [N];
  int            src_pos  [N];
  logic [DW-1:0] src_dat  [N];
  logic [N-1:0]  src_gate;
  logic [N-1:0]  hs;
  logic          prev_act;
  logic [DW-1:0] wr_log [$];
  int            gnt_log [$];

  async_fifo_wr_arbiter #(
    .NUM_REQ      (N),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_active (grant_active),
    .grant_idx    (grant_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = (src_left[i] > 0) && !src_gate[i];
      req_data[i*DW +: DW]    = src_dat[i];
      req_last[i]             = (src_left[i] == 1) || (src_pos[i] == src_plen[i] - 1);
    end
  endtask

  task automatic load(input int i, input int left, input int plen, input logic [DW-1:0] d);
    src_left[i] = left;
    src_plen[i] = plen;
    src_pos[i]  = 0;
    src_dat[i]  = d;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    gnt_log.delete();
  endtask

  function automatic logic srcs_empty();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += src_left[i];
    return (s == 0);
  endfunction

  // One clock: log on the falling edge, advance sources just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    hs = req_valid & req_ready;
    if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
    if (grant_active && !prev_act) gnt_log.push_back(int'(grant_idx));
    prev_act = grant_active;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        src_dat[i]  = src_dat[i] + 8'd1;
        src_left[i] = src_left[i] - 1;
        src_pos[i]  = (src_pos[i] + 1 == src_plen[i]) ? 0 : src_pos[i] + 1;
      end
    end
    drive_src();
    #1;
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      done = srcs_empty() && !grant_active;
    end
    vec++;
    if (!done) begin
      errs++;
      $display("FAIL drain_timeout: sources still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    src_gate  = '0;
    prev_act  = 1'b0;
    for (int i = 0; i < N; i++) load(i, 1, 1, 8'hE0);
    drive_src();
    #1;
    vec++;
    if ({grant_active, fifo_wr_en, req_ready} !== 6'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got act/wr/rdy=%b required 000000", {grant_active, fifo_wr_en, req_ready});
    end
    vec++;
    if (grant_idx !== 2'd0) begin
      errs++;
      $display("FAIL reset_idx: got %0d required 0", grant_idx);
    end
    vec++;
    if (fifo_wr_data !== 8'h00) begin
      errs++;
      $display("FAIL reset_data: got %h required 00", fifo_wr_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) load(i, 0, 1, 8'h00);
    drive_src();
    #1;
    rst_n = 1'b1;
    cycle();
    cycle();
    vec++;
    if (grant_active !== 1'b0) begin
      errs++;
      $display("FAIL idle_no_req: grant_active got %b required 0", grant_active);
    end
  endtask

  task automatic test_single();
    clear_logs();
    load(0, 3, 3, 8'h10);
    drive_src();
    #1;
    vec++;
    if ({grant_active, req_ready} !== 5'b0) begin
      errs++;
      $display("FAIL single_bubble: act/rdy got %b required 00000", {grant_active, req_ready});
    end
    for (int b = 0; b < 3; b++) begin
      cycle();
      vec++;
      if ({grant_active, grant_idx, fifo_wr_en, req_ready} !== 8'b1_00_1_0001 || fifo_wr_data !== 8'h10 + 8'(b)) begin
        errs++;
        $display("FAIL single_beat%0d: act/idx/wr/rdy=%b data=%h required 10010001 data=%h",
                 b, {grant_active, grant_idx, fifo_wr_en, req_ready}, fifo_wr_data, 8'h10 + 8'(b));
      end
    end
    cycle();
    vec++;
    if (grant_active !== 1'b0) begin
      errs++;
      $display("FAIL single_release: grant_active got %b required 0", grant_active);
    end
    vec++;
    if (dut.rr_ptr_q !== 2'd0) begin
      errs++;
      $display("FAIL single_rr_ptr: got %0d required 0", dut.rr_ptr_q);
    end
    vec++;
    if (wr_log.size() != 3) begin
      errs++;
      $display("FAIL single_count: got %0d writes required 3", wr_log.size());
    end
  endtask

  task automatic test_round_robin();
    int order [5];
    logic [DW-1:0] exp_w [5];
    logic exp_act;
    order = '{0, 1, 2, 3, 0};
    exp_w = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h21};
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    prev_act = 1'b0;
    clear_logs();
    load(0, 2, 1, 8'h20);
    load(1, 1, 1, 8'h30);
    load(2, 1, 1, 8'h40);
    load(3, 1, 1, 8'h50);
    drive_src();
    for (int c = 1; c <= 10; c++) begin
      cycle();
      exp_act = (c % 2 == 1);
      vec++;
      if (grant_active !== exp_act) begin
        errs++;
        $display("FAIL rr_active_c%0d: got %b required %b", c, grant_active, exp_act);
      end
      if (exp_act) begin
        vec++;
        if (int'(grant_idx) != order[(c-1)/2] || fifo_wr_en !== 1'b1) begin
          errs++;
          $display("FAIL rr_grant_c%0d: idx=%0d wr=%b required idx=%0d wr=1",
                   c, grant_idx, fifo_wr_en, order[(c-1)/2]);
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (k >= wr_log.size() || wr_log[k] !== exp_w[k]) begin
        errs++;
        $display("FAIL rr_data%0d: got %h required %h", k, (k < wr_log.size()) ? wr_log[k] : 8'hxx, exp_w[k]);
      end
    end
  endtask

  task automatic test_burst_split();
    logic [DW-1:0] exp_w [12];
    int exp_g [4];
    exp_w = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h60, 8'h61,
              8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    exp_g = '{2, 3, 2, 2};
    clear_logs();
    load(2, 10, 10, 8'h40);
    load(3, 2, 2, 8'h60);
    drive_src();
    drain(60);
    vec++;
    if (wr_log.size() != 12) begin
      errs++;
      $display("FAIL burst_count: got %0d writes required 12", wr_log.size());
    end
    for (int k = 0; k < 12; k++) begin
      vec++;
      if (k >= wr_log.size() || wr_log[k] !== exp_w[k]) begin
        errs++;
        $display("FAIL burst_data%0d: got %h required %h", k, (k < wr_log.size()) ? wr_log[k] : 8'hxx, exp_w[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (k >= gnt_log.size() || gnt_log[k] != exp_g[k]) begin
        errs++;
        $display("FAIL burst_grant%0d: got %0d required %0d", k, (k < gnt_log.size()) ? gnt_log[k] : -1, exp_g[k]);
      end
    end
  endtask

  task automatic test_full_hold();
    clear_logs();
    load(1, 3, 3, 8'h70);
    drive_src();
    cycle();
    vec++;
    if (grant_idx !== 2'd1 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h70) begin
      errs++;
      $display("FAIL full_first: idx=%0d wr=%b data=%h required 1 1 70", grant_idx, fifo_wr_en, fifo_wr_data);
    end
    cycle();
    fifo_full = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      vec++;
      if ({grant_active, fifo_wr_en, req_ready} !== 6'b10_0000 || grant_idx !== 2'd1) begin
        errs++;
        $display("FAIL full_hold%0d: act/wr/rdy=%b idx=%0d required 100000 idx=1",
                 k, {grant_active, fifo_wr_en, req_ready}, grant_idx);
      end
      cycle();
    end
    fifo_full = 1'b0;
    #1;
    vec++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h71 || req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL full_resume: wr=%b data=%h rdy=%b required 1 71 0010", fifo_wr_en, fifo_wr_data, req_ready);
    end
    drain(10);
    vec++;
    if (wr_log.size() != 3 || wr_log[1] !== 8'h71 || wr_log[2] !== 8'h72) begin
      errs++;
      $display("FAIL full_order: got %0d writes, required 70 71 72", wr_log.size());
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] exp_w [4];
    exp_w = '{8'h80, 8'h90, 8'h81, 8'h82};
    clear_logs();
    load(3, 3, 3, 8'h80);
    load(0, 1, 1, 8'h90);
    drive_src();
    cycle();
    vec++;
    if (grant_idx !== 2'd3 || fifo_wr_data !== 8'h80) begin
      errs++;
      $display("FAIL to_first: idx=%0d data=%h required 3 80", grant_idx, fifo_wr_data);
    end
    cycle();
    src_gate[3] = 1'b1;
    drive_src();
    #1;
    for (int k = 0; k < 8; k++) begin
      vec++;
      if ({grant_active, fifo_wr_en, req_ready} !== 6'b10_1000) begin
        errs++;
        $display("FAIL to_wait%0d: act/wr/rdy=%b required 101000", k, {grant_active, fifo_wr_en, req_ready});
      end
      cycle();
    end
    vec++;
    if (grant_active !== 1'b0) begin
      errs++;
      $display("FAIL to_release: grant_active got %b required 0", grant_active);
    end
    cycle();
    vec++;
    if (grant_active !== 1'b1 || grant_idx !== 2'd0 || fifo_wr_data !== 8'h90) begin
      errs++;
      $display("FAIL to_next: act=%b idx=%0d data=%h required 1 0 90", grant_active, grant_idx, fifo_wr_data);
    end
    src_gate[3] = 1'b0;
    drive_src();
    drain(20);
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (k >= wr_log.size() || wr_log[k] !== exp_w[k]) begin
        errs++;
        $display("FAIL to_data%0d: got %h required %h", k, (k < wr_log.size()) ? wr_log[k] : 8'hxx, exp_w[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    load(2, 4, 4, 8'hA0);
    drive_src();
    cycle();
    vec++;
    if (grant_idx !== 2'd2 || fifo_wr_en !== 1'b1) begin
      errs++;
      $display("FAIL rm_grant: idx=%0d wr=%b required 2 1", grant_idx, fifo_wr_en);
    end
    cycle();
    load(0, 1, 1, 8'hB0);
    drive_src();
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({grant_active, fifo_wr_en, req_ready} !== 6'b0 || fifo_wr_data !== 8'h00) begin
      errs++;
      $display("FAIL rm_async: act/wr/rdy=%b data=%h required 000000 00",
               {grant_active, fifo_wr_en, req_ready}, fifo_wr_data);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    prev_act = 1'b0;
    cycle();
    vec++;
    if (grant_active !== 1'b1 || grant_idx !== 2'd0 || fifo_wr_data !== 8'hB0) begin
      errs++;
      $display("FAIL rm_regrant: act=%b idx=%0d data=%h required 1 0 B0", grant_active, grant_idx, fifo_wr_data);
    end
    load(2, 0, 1, 8'h00);
    drive_src();
    drain(10);
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_split();
    test_full_hold();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
